// File: rtl/mc_ctl.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB with
// variable-latency memory handshakes, registered decode fields and trap handling.
module mc_ctl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNTER_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 branch_taken,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 pc_write,
  output logic                 pc_sel,
  output logic                 reg_write,
  output logic [5:0]           i_format,
  output logic [2:0]           bj_type,
  output logic [1:0]           U_sel,
  output logic [5:0]           alu_op,
  output logic                 alu_src,
  output logic                 mem_to_reg,
  output logic                 retire,
  output logic [COUNTER_W-1:0] instret,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t                 state_reg, state_next;
  logic [6:0]             op_reg;
  logic [2:0]             f3_reg;
  logic [5:0]             i_format_reg, alu_op_reg;
  logic [2:0]             bj_type_reg;
  logic [1:0]             u_sel_reg;
  logic                   alu_src_reg, mem_to_reg_reg;
  logic                   is_load_reg, is_store_reg, is_branch_reg, is_jump_reg;
  logic [COUNTER_W-1:0]   instret_reg;
  logic                   trap_reg;
  logic [1:0]             trap_cause_reg, trap_cause_next;
  logic [TW-1:0]          wait_cnt_reg;

  logic       dec_legal, dec_src, dec_m2r, dec_load, dec_store, dec_branch, dec_jump;
  logic [5:0] dec_fmt;
  logic [2:0] dec_bj;
  logic [1:0] dec_u;

  logic imem_req_c, ir_write_c, dmem_req_c, dmem_we_c;
  logic pc_write_c, pc_sel_c, reg_write_c, retire_c;
  logic timeout_hit;

  // Only opcode and funct3 matter to the controller; the datapath owns the full IR.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  always_comb begin
    dec_legal  = 1'b1;
    dec_fmt    = '0;
    dec_bj     = '0;
    dec_u      = '0;
    dec_src    = 1'b0;
    dec_m2r    = 1'b0;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_branch = 1'b0;
    dec_jump   = 1'b0;
    case (op_reg)
      OP_R:     dec_fmt = FMT_R;
      OP_IMM:   begin dec_fmt = FMT_I; dec_src = 1'b1; end
      OP_LOAD:  begin dec_fmt = FMT_I; dec_src = 1'b1; dec_m2r = 1'b1; dec_load = 1'b1; end
      OP_STORE: begin dec_fmt = FMT_S; dec_src = 1'b1; dec_store = 1'b1; end
      OP_BRANCH: begin
        dec_fmt    = FMT_B;
        dec_branch = 1'b1;
        case (f3_reg)
          3'b000:  dec_bj = 3'd1;
          3'b001:  dec_bj = 3'd2;
          3'b100:  dec_bj = 3'd3;
          3'b101:  dec_bj = 3'd4;
          3'b110:  dec_bj = 3'd5;
          3'b111:  dec_bj = 3'd6;
          default: dec_legal = 1'b0;
        endcase
      end
      OP_JAL:   begin dec_fmt = FMT_J; dec_bj = 3'd1; dec_jump = 1'b1; end
      OP_JALR: begin
        dec_fmt   = FMT_I;
        dec_src   = 1'b1;
        dec_bj    = 3'd2;
        dec_jump  = 1'b1;
        dec_legal = (f3_reg == 3'b000);
      end
      OP_LUI:   begin dec_fmt = FMT_U; dec_u = 2'd1; dec_src = 1'b1; end
      OP_AUIPC: begin dec_fmt = FMT_U; dec_u = 2'd2; dec_src = 1'b1; end
      default:  dec_legal = 1'b0;
    endcase
  end

  // Fires on the last allowed wait cycle; a ready in that same cycle takes priority.
  assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt_reg == TW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_next      = state_reg;
    trap_cause_next = 2'b00;
    imem_req_c      = 1'b0;
    ir_write_c      = 1'b0;
    dmem_req_c      = 1'b0;
    dmem_we_c       = 1'b0;
    pc_write_c      = 1'b0;
    pc_sel_c        = 1'b0;
    reg_write_c     = 1'b0;
    retire_c        = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next      = S_TRAP;
          trap_cause_next = 2'b10;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_next = S_EXEC;
        end else begin
          state_next      = S_TRAP;
          trap_cause_next = 2'b01;
        end
      end
      S_EXEC: begin
        if (is_load_reg || is_store_reg) begin
          state_next = S_MEM;
        end else if (is_branch_reg) begin
          pc_write_c = 1'b1;
          pc_sel_c   = branch_taken;
          retire_c   = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store_reg;
        if (dmem_ready) begin
          if (is_store_reg) begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (timeout_hit) begin
          state_next      = S_TRAP;
          trap_cause_next = 2'b11;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        pc_sel_c    = is_jump_reg;
        retire_c    = 1'b1;
        state_next  = S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_FETCH;
      op_reg         <= '0;
      f3_reg         <= '0;
      i_format_reg   <= '0;
      alu_op_reg     <= '0;
      bj_type_reg    <= '0;
      u_sel_reg      <= '0;
      alu_src_reg    <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      is_load_reg    <= 1'b0;
      is_store_reg   <= 1'b0;
      is_branch_reg  <= 1'b0;
      is_jump_reg    <= 1'b0;
      instret_reg    <= '0;
      trap_reg       <= 1'b0;
      trap_cause_reg <= 2'b00;
      wait_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (ir_write_c) begin
        op_reg <= instr[6:0];
        f3_reg <= instr[14:12];
      end
      if (state_reg == S_DECODE && dec_legal) begin
        i_format_reg   <= dec_fmt;
        alu_op_reg     <= dec_fmt;
        bj_type_reg    <= dec_bj;
        u_sel_reg      <= dec_u;
        alu_src_reg    <= dec_src;
        mem_to_reg_reg <= dec_m2r;
        is_load_reg    <= dec_load;
        is_store_reg   <= dec_store;
        is_branch_reg  <= dec_branch;
        is_jump_reg    <= dec_jump;
      end
      if (state_next == S_TRAP && state_reg != S_TRAP) begin
        trap_reg       <= 1'b1;
        trap_cause_reg <= trap_cause_next;
        alu_op_reg     <= '0;
      end
      if (retire_c) instret_reg <= instret_reg + 1'b1;
      if (state_next != state_reg)
        wait_cnt_reg <= '0;
      else if ((imem_req_c && !imem_ready) || (dmem_req_c && !dmem_ready))
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  // Strobes are forced low while reset is held so an aborted access drops at once.
  assign imem_req  = rst_n & imem_req_c;
  assign ir_write  = rst_n & ir_write_c;
  assign dmem_req  = rst_n & dmem_req_c;
  assign dmem_we   = rst_n & dmem_we_c;
  assign pc_write  = rst_n & pc_write_c;
  assign pc_sel    = rst_n & pc_sel_c;
  assign reg_write = rst_n & reg_write_c;
  assign retire    = rst_n & retire_c;

  assign i_format   = i_format_reg;
  assign bj_type    = bj_type_reg;
  assign U_sel      = u_sel_reg;
  assign alu_op     = alu_op_reg;
  assign alu_src    = alu_src_reg;
  assign mem_to_reg = mem_to_reg_reg;
  assign instret    = instret_reg;
  assign trap       = trap_reg;
  assign trap_cause = trap_cause_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_mc_ctl.sv
// Directed bench for mc_ctl: per-feature tasks with hand-computed expectations.
module tb_mc_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, branch_taken;
  logic        imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_sel, reg_write, retire;
  logic [5:0]  i_format, alu_op;
  logic [2:0]  bj_type, state;
  logic [1:0]  U_sel, trap_cause;
  logic        alu_src, mem_to_reg, trap;
  logic [3:0]  instret;

  int checks = 0;
  int errors = 0;

  // Strobe bundle: imem_req ir_write dmem_req dmem_we pc_write pc_sel reg_write retire
  logic [7:0] strb;
  assign strb = {imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_sel, reg_write, retire};

  always #5 clk = ~clk;

  mc_ctl #(.MEM_TIMEOUT(4), .COUNTER_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken), .imem_req(imem_req),
    .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we), .pc_write(pc_write),
    .pc_sel(pc_sel), .reg_write(reg_write), .i_format(i_format), .bj_type(bj_type),
    .U_sel(U_sel), .alu_op(alu_op), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .retire(retire), .instret(instret), .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    instr = 32'h0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    branch_taken = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    #1;
  endtask

  // Presents one instruction with a zero-wait fetch; returns in DECODE.
  task automatic fetch(input logic [31:0] w);
    instr = w;
    imem_ready = 1'b1;
    tick;
    imem_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    instr = 32'h003100B3;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    branch_taken = 1'b0;
    tick;
    #1;
    checks++; if (strb !== 8'b0) begin errors++; $display("FAIL reset_strobes got %b want %b", strb, 8'b0); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if ({trap, trap_cause, instret} !== 7'b0) begin errors++; $display("FAIL reset_trap_instret got %b want 0", {trap, trap_cause, instret}); end
    checks++; if ({i_format, alu_op, bj_type, U_sel} !== 17'b0) begin errors++; $display("FAIL reset_decode got %h want 0", {i_format, alu_op, bj_type, U_sel}); end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (strb !== 8'b1000_0000) begin errors++; $display("FAIL reset_release_strobes got %b want %b", strb, 8'b1000_0000); end
  endtask

  task automatic test_add;
    instr = 32'h003100B3;
    imem_ready = 1'b1;
    #1;
    checks++; if ({state, strb} !== {3'd0, 8'b1100_0000}) begin errors++; $display("FAIL add_fetch got st=%0d strb=%b want st=0 strb=11000000", state, strb); end
    tick; imem_ready = 1'b0; #1;
    checks++; if ({state, strb} !== {3'd1, 8'b0}) begin errors++; $display("FAIL add_decode got st=%0d strb=%b want st=1 strb=0", state, strb); end
    tick; #1;
    checks++; if ({state, i_format} !== {3'd2, 6'b000001}) begin errors++; $display("FAIL add_exec got st=%0d fmt=%b want st=2 fmt=000001", state, i_format); end
    tick; #1;
    checks++; if ({state, strb} !== {3'd4, 8'b0000_1011}) begin errors++; $display("FAIL add_wb got st=%0d strb=%b want st=4 strb=00001011", state, strb); end
    checks++; if ({alu_op, instret} !== {6'b000001, 4'd0}) begin errors++; $display("FAIL add_wb_aluop got op=%b ir=%0d want op=000001 ir=0", alu_op, instret); end
    tick; #1;
    checks++; if ({state, instret} !== {3'd0, 4'd1}) begin errors++; $display("FAIL add_done got st=%0d instret=%0d want st=0 instret=1", state, instret); end
  endtask

  task automatic test_load_wait;
    fetch(32'h0002A083);
    tick; #1;
    checks++; if ({state, i_format, alu_src} !== {3'd2, 6'b000010, 1'b1}) begin errors++; $display("FAIL lw_exec got st=%0d fmt=%b src=%b want st=2 fmt=000010 src=1", state, i_format, alu_src); end
    for (int c = 1; c <= 3; c++) begin
      tick;
      dmem_ready = (c == 3);
      #1;
      checks++; if ({state, strb} !== {3'd3, 8'b0010_0000}) begin errors++; $display("FAIL lw_mem%0d got st=%0d strb=%b want st=3 strb=00100000", c, state, strb); end
    end
    tick; dmem_ready = 1'b0; #1;
    checks++; if ({state, strb, mem_to_reg} !== {3'd4, 8'b0000_1011, 1'b1}) begin errors++; $display("FAIL lw_wb got st=%0d strb=%b m2r=%b want st=4 strb=00001011 m2r=1", state, strb, mem_to_reg); end
    tick; #1;
    checks++; if ({state, instret} !== {3'd0, 4'd2}) begin errors++; $display("FAIL lw_done got st=%0d instret=%0d want st=0 instret=2", state, instret); end
  endtask

  task automatic test_branch(input logic taken, input logic [3:0] exp_instret);
    fetch(32'h00000463);
    tick;
    branch_taken = taken;
    #1;
    checks++; if ({state, strb} !== {3'd2, 5'b00001, taken, 2'b01}) begin errors++; $display("FAIL beq_exec_t%0b got st=%0d strb=%b want st=2 pc_sel=%0b", taken, state, strb, taken); end
    checks++; if ({bj_type, alu_op} !== {3'd1, 6'b001000}) begin errors++; $display("FAIL beq_fields_t%0b got bj=%0d op=%b want bj=1 op=001000", taken, bj_type, alu_op); end
    tick; branch_taken = 1'b0; #1;
    checks++; if ({state, instret} !== {3'd0, exp_instret}) begin errors++; $display("FAIL beq_done_t%0b got st=%0d instret=%0d want st=0 instret=%0d", taken, state, instret, exp_instret); end
  endtask

  task automatic test_jal;
    fetch(32'h0080006F);
    tick; tick; #1;
    checks++; if ({state, strb, bj_type, i_format} !== {3'd4, 8'b0000_1111, 3'd1, 6'b100000}) begin errors++; $display("FAIL jal_wb got st=%0d strb=%b bj=%0d fmt=%b want st=4 strb=00001111 bj=1 fmt=100000", state, strb, bj_type, i_format); end
    tick; #1;
  endtask

  task automatic test_store_ready_at_limit;
    fetch(32'h00112023);
    tick; #1;
    checks++; if ({state, i_format} !== {3'd2, 6'b000100}) begin errors++; $display("FAIL sw_exec got st=%0d fmt=%b want st=2 fmt=000100", state, i_format); end
    for (int c = 1; c <= 4; c++) begin
      tick;
      dmem_ready = (c == 4);
      #1;
      if (c < 4) begin
        checks++; if ({state, strb} !== {3'd3, 8'b0011_0000}) begin errors++; $display("FAIL sw_mem%0d got st=%0d strb=%b want st=3 strb=00110000", c, state, strb); end
      end else begin
        checks++; if ({state, strb} !== {3'd3, 8'b0011_1001}) begin errors++; $display("FAIL sw_mem4_ready got st=%0d strb=%b want st=3 strb=00111001", state, strb); end
      end
    end
    tick; dmem_ready = 1'b0; #1;
    checks++; if ({state, trap, instret} !== {3'd0, 1'b0, 4'd6}) begin errors++; $display("FAIL sw_done got st=%0d trap=%b instret=%0d want st=0 trap=0 instret=6", state, trap, instret); end
  endtask

  task automatic test_dmem_timeout;
    fetch(32'h00112023);
    tick; tick;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if ({state, strb} !== {3'd3, 8'b0011_0000}) begin errors++; $display("FAIL dto_mem%0d got st=%0d strb=%b want st=3 strb=00110000", c, state, strb); end
      tick;
    end
    #1;
    checks++; if ({state, trap, trap_cause, strb} !== {3'd7, 1'b1, 2'b11, 8'b0}) begin errors++; $display("FAIL dto_trap got st=%0d trap=%b cause=%b strb=%b want st=7 trap=1 cause=11 strb=0", state, trap, trap_cause, strb); end
    checks++; if ({alu_op, instret} !== {6'b0, 4'd6}) begin errors++; $display("FAIL dto_frozen got op=%b instret=%0d want op=0 instret=6", alu_op, instret); end
  endtask

  task automatic test_illegal_all_ones;
    int bad;
    do_reset;
    fetch(32'hFFFFFFFF);
    #1;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL ill_decode got st=%0d want 1", state); end
    tick; #1;
    checks++; if ({state, trap, trap_cause, alu_op} !== {3'd7, 1'b1, 2'b01, 6'b0}) begin errors++; $display("FAIL ill_trap got st=%0d trap=%b cause=%b op=%b want st=7 trap=1 cause=01 op=0", state, trap, trap_cause, alu_op); end
    bad = 0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    branch_taken = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick; #1;
      if (strb !== 8'b0 || state !== 3'd7 || trap_cause !== 2'b01 || instret !== 4'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ill_hold got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_illegal_branch;
    do_reset;
    fetch(32'h00002463);
    tick; #1;
    checks++; if ({state, trap_cause} !== {3'd7, 2'b01}) begin errors++; $display("FAIL ill_br got st=%0d cause=%b want st=7 cause=01", state, trap_cause); end
  endtask

  task automatic test_imem_timeout;
    do_reset;
    tick; tick; tick; #1;
    checks++; if ({state, strb} !== {3'd0, 8'b1000_0000}) begin errors++; $display("FAIL ito_wait got st=%0d strb=%b want st=0 strb=10000000", state, strb); end
    tick; #1;
    checks++; if ({state, trap_cause, strb} !== {3'd7, 2'b10, 8'b0}) begin errors++; $display("FAIL ito_trap got st=%0d cause=%b strb=%b want st=7 cause=10 strb=0", state, trap_cause, strb); end
  endtask

  task automatic test_back_to_back_wrap;
    do_reset;
    for (int n = 1; n <= 17; n++) begin
      fetch(32'h00108093);
      tick; tick; tick;
      if (n == 16) begin
        checks++; if ({state, instret} !== {3'd0, 4'd0}) begin errors++; $display("FAIL wrap16 got st=%0d instret=%0d want st=0 instret=0", state, instret); end
      end
    end
    checks++; if ({state, instret} !== {3'd0, 4'd1}) begin errors++; $display("FAIL wrap17 got st=%0d instret=%0d want st=0 instret=1", state, instret); end
  endtask

  task automatic test_reset_in_mem;
    fetch(32'h0002A083);
    tick; tick; #1;
    checks++; if ({state, strb} !== {3'd3, 8'b0010_0000}) begin errors++; $display("FAIL rmem_pre got st=%0d strb=%b want st=3 strb=00100000", state, strb); end
    rst_n = 1'b0;
    #1;
    checks++; if ({state, strb, instret} !== {3'd0, 8'b0, 4'd0}) begin errors++; $display("FAIL rmem_assert got st=%0d strb=%b instret=%0d want st=0 strb=0 instret=0", state, strb, instret); end
    tick;
    rst_n = 1'b1;
    #1;
    checks++; if ({state, strb} !== {3'd0, 8'b1000_0000}) begin errors++; $display("FAIL rmem_release got st=%0d strb=%b want st=0 strb=10000000", state, strb); end
    tick; #1;
    checks++; if ({state, instret} !== {3'd0, 4'd0}) begin errors++; $display("FAIL rmem_after got st=%0d instret=%0d want st=0 instret=0", state, instret); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_load_wait;
    test_branch(1'b1, 4'd3);
    test_branch(1'b0, 4'd4);
    test_jal;
    test_store_ready_at_limit;
    test_dmem_timeout;
    test_illegal_all_ones;
    test_illegal_branch;
    test_imem_timeout;
    test_back_to_back_wrap;
    test_reset_in_mem;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
